gost_block_core: RTL and testbench

GOST_BLOCK_CORE -- requirements
Module: gost_block_core

---
 rtl/gost_block_core.sv | 148 ++++++++++++++
 tb/tb_gost_block_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gost_block_core.sv
// GOST 64-bit block cipher core (Magma / GOST 28147-89), iterative Feistel engine.
// Latency: out_valid rises 32/ROUNDS_PER_CYCLE cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; no new request is taken until then.
module gost_block_core #(
  parameter int ROUNDS_PER_CYCLE = 1,  // 1, 2, 4 or 8
  parameter int SBOX_SET         = 0   // 0: tc26 "Z" (Magma), 1: CryptoPro A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [255:0] key,
  input  logic [63:0]  data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  // Counter value at which the current cycle completes round 32.
  localparam logic [4:0] LAST_STEP = 5'(32 - ROUNDS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [31:0]  l_q, r_q;
  logic [255:0] key_q;
  logic         mode_q;
  logic [4:0]   cnt;
  logic [31:0]  l_nxt, r_nxt;

  // Row for S-box i; entry x lives in bits [4x+3:4x].
  function automatic logic [3:0] sbox(input int i, input logic [3:0] x);
    logic [63:0] row;
    row = 64'h0;
    if (SBOX_SET == 0) begin
      case (i)
        0: row = 64'h1F307D8E9B5A264C;
        1: row = 64'hF0DB74E1C5A93286;
        2: row = 64'h069C471EDAF2853B;
        3: row = 64'hB9E35A076F4D128C;
        4: row = 64'hC24BE390D618A5F7;
        5: row = 64'h0E34187BAC296FD5;
        6: row = 64'h73AD0B4FC19652E8;
        default: row = 64'h2BC96AF43850DE71;
      endcase
    end else begin
      case (i)
        0: row = 64'h5D0CFE4A71B82369;
        1: row = 64'h1D4BC6250FA89E73;
        2: row = 64'h9170A5FC8D3B264E;
        3: row = 64'h658F4B20931DCA7E;
        4: row = 64'h6A7C324E0FD8915B;
        5: row = 64'h6EF84957B021CDA3;
        6: row = 64'hEB3F54C806A792D1;
        default: row = 64'h4D7193268EC05FAB;
      endcase
    end
    return row[{x, 2'b00} +: 4];
  endfunction

  // g(R,K) = ROL11(S(R + K mod 2^32)).
  function automatic logic [31:0] g_func(input logic [31:0] r, input logic [31:0] k);
    logic [31:0] s, t;
    s = r + k;
    t = 32'h0;
    for (int i = 0; i < 8; i++) t[4*i +: 4] = sbox(i, s[4*i +: 4]);
    return {t[20:0], t[31:21]};
  endfunction

  // Subkey for round r (0-based): forward index while in the repeated section, reversed after.
  function automatic logic [31:0] round_key(input logic [4:0] r, input logic dec,
                                            input logic [255:0] k);
    logic       fwd;
    logic [2:0] ki;
    fwd = dec ? (r < 5'd8) : (r < 5'd24);
    ki  = fwd ? r[2:0] : ~r[2:0];
    // K1 sits in the top word, so word index ki starts at bit 32*(7-ki).
    return k[{~ki, 5'b00000} +: 32];
  endfunction

  // Cascade of ROUNDS_PER_CYCLE Feistel rounds starting at round cnt.
  always_comb begin
    logic [31:0] l_t, r_t, f_t;
    l_t = l_q;
    r_t = r_q;
    f_t = 32'h0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      f_t = l_t ^ g_func(r_t, round_key(cnt + 5'(j), mode_q, key_q));
      l_t = r_t;
      r_t = f_t;
    end
    l_nxt = l_t;
    r_nxt = r_t;
  end

  // Control FSM with datapath registers; result is captured on the last RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      l_q       <= 32'h0;
      r_q       <= 32'h0;
      key_q     <= 256'h0;
      mode_q    <= 1'b0;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      data_out  <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            l_q    <= data_in[63:32];
            r_q    <= data_in[31:0];
            key_q  <= key;
            mode_q <= mode;
            cnt    <= 5'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          l_q <= l_nxt;
          r_q <= r_nxt;
          if (cnt == LAST_STEP) begin
            // Output is {R32, L32}: undoing the last swap gives the standard final round.
            data_out  <= {r_nxt, l_nxt};
            out_valid <= 1'b1;
            cnt       <= 5'd31;
            state     <= DONE;
          end else begin
            cnt <= cnt + 5'(ROUNDS_PER_CYCLE);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gost_block_core.sv
// Bench for gost_block_core: four instances (1/2/4/8 rounds per cycle) sharing request data.
// Expected results come from an independent Magma model pushed to a scoreboard queue.
// Each instance has its own in_valid/out_ready so only one is exercised at a time.
module tb_gost_block_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic [255:0] key = '0;
  logic [63:0]  data_in = '0;
  logic [3:0]   iv = '0;
  logic [3:0]   ordy = '0;
  logic [3:0]   irdy, ov, bsy;
  logic [3:0][63:0] dout;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  localparam logic [255:0] TV_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  TV_PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  TV_CT  = 64'h4ee901e5c2d8ca3d;

  always #5 clk = ~clk;

  for (genvar u = 0; u < 4; u++) begin : g_dut
    gost_block_core #(.ROUNDS_PER_CYCLE(1 << u), .SBOX_SET(0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[u]),
      .in_ready  (irdy[u]),
      .mode      (mode),
      .key       (key),
      .data_in   (data_in),
      .out_valid (ov[u]),
      .out_ready (ordy[u]),
      .data_out  (dout[u]),
      .busy      (bsy[u])
    );
  end

  // Magma substitution table, pi_z[n] applies to nibble n (n = 0 least significant).
  logic [3:0] pi_z [8][16] = '{
    '{4'hC,4'h4,4'h6,4'h2,4'hA,4'h5,4'hB,4'h9,4'hE,4'h8,4'hD,4'h7,4'h0,4'h3,4'hF,4'h1},
    '{4'h6,4'h8,4'h2,4'h3,4'h9,4'hA,4'h5,4'hC,4'h1,4'hE,4'h4,4'h7,4'hB,4'hD,4'h0,4'hF},
    '{4'hB,4'h3,4'h5,4'h8,4'h2,4'hF,4'hA,4'hD,4'hE,4'h1,4'h7,4'h4,4'hC,4'h9,4'h6,4'h0},
    '{4'hC,4'h8,4'h2,4'h1,4'hD,4'h4,4'hF,4'h6,4'h7,4'h0,4'hA,4'h5,4'h3,4'hE,4'h9,4'hB},
    '{4'h7,4'hF,4'h5,4'hA,4'h8,4'h1,4'h6,4'hD,4'h0,4'h9,4'h3,4'hE,4'hB,4'h4,4'h2,4'hC},
    '{4'h5,4'hD,4'hF,4'h6,4'h9,4'h2,4'hC,4'hA,4'hB,4'h7,4'h8,4'h1,4'h4,4'h3,4'hE,4'h0},
    '{4'h8,4'hE,4'h2,4'h5,4'h6,4'h9,4'h1,4'hC,4'hF,4'h4,4'hB,4'h0,4'hD,4'hA,4'h3,4'h7},
    '{4'h1,4'h7,4'hE,4'hD,4'h0,4'h5,4'h8,4'h3,4'h4,4'hF,4'hA,4'h6,4'h9,4'hC,4'hB,4'h2}
  };

  // Reference: explicit 32-entry schedule, decrypt walks it backwards, last round unswapped.
  function automatic logic [63:0] model(input logic [255:0] k, input logic [63:0] d, input logic dec);
    logic [31:0] ks [32];
    logic [31:0] a1, a0, s, sub, t;
    for (int i = 0; i < 8; i++) begin
      ks[i]      = k[255 - 32*i -: 32];
      ks[8 + i]  = ks[i];
      ks[16 + i] = ks[i];
      ks[24 + i] = k[255 - 32*(7 - i) -: 32];
    end
    a1 = d[63:32];
    a0 = d[31:0];
    for (int i = 0; i < 32; i++) begin
      s = a0 + ks[dec ? 31 - i : i];
      for (int n = 0; n < 8; n++) sub[4*n +: 4] = pi_z[n][s[4*n +: 4]];
      t = ((sub << 11) | (sub >> 21)) ^ a1;
      if (i < 31) begin
        a1 = a0;
        a0 = t;
      end else begin
        a1 = t;
      end
    end
    return {a1, a0};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request to instance u, accept on the next edge, then scramble the shared inputs.
  task automatic start_op(input int u, input logic m, input logic [255:0] k, input logic [63:0] d);
    mode    = m;
    key     = k;
    data_in = d;
    iv[u]   = 1'b1;
    sb.push_back(model(k, d, m));
    @(posedge clk);
    #1;
    iv[u]   = 1'b0;
    check("accept_in_ready_low", 64'(irdy[u]), 64'd0);
    check("accept_busy_high", 64'(bsy[u]), 64'd1);
    key     = rand256();
    data_in = {$urandom, $urandom};
    mode    = ~m;
  endtask

  task automatic wait_out(input int u, input int exp_lat);
    int lat;
    lat = 0;
    while (ov[u] !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_op(input int u, output logic [63:0] res);
    logic [63:0] exp;
    exp = sb.pop_front();
    res = dout[u];
    check("data_out", dout[u], exp);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    ordy[u] = 1'b0;
    check("post_handshake_in_ready", 64'(irdy[u]), 64'd1);
    check("post_handshake_out_valid", 64'(ov[u]), 64'd0);
  endtask

  initial begin
    logic [63:0]  res, ct;
    logic [255:0] rk;
    logic [63:0]  rp;
    int u;

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_in_ready", 64'(irdy[i]), 64'd1);
      check("rst_out_valid", 64'(ov[i]), 64'd0);
      check("rst_busy", 64'(bsy[i]), 64'd0);
      check("rst_data_out", dout[i], 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Known-answer encrypt on the first edge after reset, then decrypt.
    start_op(0, 1'b0, TV_KEY, TV_PT);
    wait_out(0, 32);
    finish_op(0, res);
    check("kat_encrypt", res, TV_CT);
    start_op(0, 1'b1, TV_KEY, TV_CT);
    wait_out(0, 32);
    finish_op(0, res);
    check("kat_decrypt", res, TV_PT);

    // Same vector on the unrolled variants.
    for (int i = 1; i < 4; i++) begin
      start_op(i, 1'b0, TV_KEY, TV_PT);
      wait_out(i, 32 >> i);
      finish_op(i, res);
      check("kat_unrolled", res, TV_CT);
    end

    // Stall in DONE while the requester keeps poking at the inputs.
    start_op(0, 1'b0, TV_KEY, TV_PT);
    wait_out(0, 32);
    for (int c = 0; c < 10; c++) begin
      iv[0]   = ~iv[0];
      data_in = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("stall_data_out", dout[0], sb[0]);
      check("stall_in_ready", 64'(irdy[0]), 64'd0);
      check("stall_out_valid", 64'(ov[0]), 64'd1);
    end
    iv[0] = 1'b0;
    finish_op(0, res);
    check("stall_busy_after", 64'(bsy[0]), 64'd0);

    // Reset after 17 rounds drops the operation.
    start_op(0, 1'b0, TV_KEY, TV_PT);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("midrun_rst_out_valid", 64'(ov[0]), 64'd0);
    check("midrun_rst_in_ready", 64'(irdy[0]), 64'd1);
    check("midrun_rst_busy", 64'(bsy[0]), 64'd0);
    check("midrun_rst_data_out", dout[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(0, 1'b0, TV_KEY, TV_PT);
    wait_out(0, 32);
    finish_op(0, res);
    check("after_rst_encrypt", res, TV_CT);

    // Random round trips, spread across all instances, issued back to back.
    for (int n = 0; n < 100; n++) begin
      u  = n % 4;
      rk = rand256();
      rp = {$urandom, $urandom};
      start_op(u, 1'b0, rk, rp);
      wait_out(u, 32 >> u);
      finish_op(u, ct);
      start_op(u, 1'b1, rk, ct);
      wait_out(u, 32 >> u);
      finish_op(u, res);
      check("round_trip", res, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
